rsa32_arb: RTL
==============

# rsa32_arb

Round-robin arbiter and sequencer that shares one rsa32 modular-exponentiation core among NREQ requesters. It sits between bus-side requester ports and the rsa32 instance. Per job it captures the winning requester's operands, issues the single start pulse, waits for the core's end strobe and returns the result with a per-requester done pulse. Only one job is in flight at a time.

## Interface
- NREQ, 2: number of requesters, 2..4.
- TIMEOUT, 1023: WAIT-cycle limit; used only when the watchdog is compiled in.
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_req  in  NREQ  per-requester job request, level.
- i_base  in  NREQ*32  base operands; requester k occupies bits [32k+31:32k].
- i_exp  in  NREQ*32  exponent operands, same packing.
- i_N  in  NREQ*32  modulus operands, same packing.
- o_gnt  out  NREQ  one-hot grant, held from capture until the done cycle.
- o_done  out  NREQ  one-cycle done pulse to the granted requester.
- o_result  out  32  result of the last job; held until the next job's end.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  pulses with o_done when a job was aborted.
- o_core_start  out  1  start pulse to the core.
- o_core_base, o_core_exp, o_core_N  out  32 each  registered operands to the core.
- i_core_result  in  32  core result.
- i_core_end  in  1  core end strobe; i_core_result is valid in the cycle it is high.

## Operation
- States:
  - IDLE: if any i_req bit is high, pick a winner by round-robin. Search starts at last_winner+1 and wraps modulo NREQ. Latch the winner's index and its three operands into o_core_*, set o_gnt, then go to START.
  - START: o_core_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: when i_core_end=1, register i_core_result into o_result and go to DONE.
  - DONE: o_done[idx]=1 for one cycle. Clear o_gnt, set last_winner=idx, then go to IDLE.
- Operands are captured once, at the grant edge. Requesters may change them after o_gnt rises.
- i_req withdrawn before grant: the request is cancelled. Withdrawn after grant: the job still runs and o_done still pulses.
- i_req is ignored in START, WAIT and DONE. It is sampled again only in IDLE, so a requester that still holds i_req after its done pulse re-enters arbitration behind the other pending requesters.
- i_core_end outside WAIT is ignored.
- i_core_end in the START cycle is ignored, because the core has not started yet.
- Reset, whether idle or mid-job:
  - Outputs and registers: state=IDLE, last_winner=NREQ-1 (so requester 0 wins first), all outputs 0 including o_result and o_core_*, watchdog counter 0.
  - A job in flight is dropped with no o_done.
  - The core shares i_rstn.

## Timing
- i_req seen in IDLE at edge t: o_gnt and o_core_* valid after t, o_core_start high in cycle t+1.
- i_core_end high in cycle c: o_result updated and o_done high in cycle c+1. o_busy falls after c+1.
- Arbitration overhead per job is 3 cycles plus core latency.
- Minimum spacing between consecutive start pulses is core latency + 4 cycles.

## Configuration
- RSA32_ARB_TIMEOUT_EN defined: a counter runs in WAIT, starting from 0 on entry to WAIT.
  - When TIMEOUT cycles elapse without i_core_end: o_result=0, go to DONE, and o_timeout pulses together with o_done.
  - If i_core_end and expiry coincide, i_core_end wins.
- Undefined: no counter, WAIT has no limit, o_timeout is tied to 0 and TIMEOUT is unused.

## Structure
- Package rsa32_arb_pkg holds:
  - the state enum (IDLE, START, WAIT, DONE);
  - RSA_W=32;
  - the per-slot operand slice helper constants.
- Sub-module rsa32_rr_pick: combinational round-robin picker. Inputs are req[NREQ] and last[clog2 NREQ]; outputs are a valid flag and the winner index.

## Test plan
- Single job: requester 0 with base=3, exp=4, N=7 -> one o_core_start pulse, o_result=4, o_done[0] one cycle, o_busy low afterwards.
- Simultaneous requests: req 0 and 1 together after reset -> 0 served first and 1 second, each with exactly one done pulse. Requester 1 uses base=2, exp=10, N=1000 -> 24.
- Fairness: requesters 0 and 1 hold i_req continuously for 4 jobs -> grant order 0,1,0,1. Operands changed after grant do not alter o_core_* (4^13 mod 497 -> 445).
- Reset mid-WAIT: assert i_rstn low during WAIT -> all outputs 0 immediately, no o_done, and the next request is served normally.
- Spurious end: i_core_end pulsed in IDLE and in START -> ignored, and the job completes on the real end.
- Watchdog (macro defined, TIMEOUT=15): core never ends -> o_done and o_timeout high together 16 cycles after entering WAIT, with o_result=0.

Source files
------------

// File: rtl/rsa32_arb_pkg.sv
// rtl/rsa32_arb_pkg.sv - shared state type and operand slot helpers for rsa32_arb
package rsa32_arb_pkg;

   localparam int RSA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Operand buses pack one RSA_W-bit slot per requester; slot k starts at k*RSA_W.
   function automatic int slot_lsb(input int k);
      return k * RSA_W;
   endfunction

endpackage

// File: rtl/rsa32_rr_pick.sv
// rtl/rsa32_rr_pick.sv - combinational round-robin picker, search starts after last winner
module rsa32_rr_pick #(
   parameter int NREQ = 2,
   parameter int LW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last,
   output logic            valid,
   output logic [LW-1:0]   idx
);

   logic [LW-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = last;
      for (int i = 0; i < NREQ; i++) begin
         cand = (cand == LW'(NREQ - 1)) ? '0 : cand + 1'b1;
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rsa32_arb.sv
// rtl/rsa32_arb.sv - round-robin sequencer sharing one rsa32 core among NREQ requesters
// Optional WAIT watchdog compiled in with RSA32_ARB_TIMEOUT_EN.
module rsa32_arb
   import rsa32_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [NREQ-1:0]       i_req,
   input  logic [NREQ*RSA_W-1:0] i_base,
   input  logic [NREQ*RSA_W-1:0] i_exp,
   input  logic [NREQ*RSA_W-1:0] i_N,
   output logic [NREQ-1:0]       o_gnt,
   output logic [NREQ-1:0]       o_done,
   output logic [RSA_W-1:0]      o_result,
   output logic                  o_busy,
   output logic                  o_timeout,
   output logic                  o_core_start,
   output logic [RSA_W-1:0]      o_core_base,
   output logic [RSA_W-1:0]      o_core_exp,
   output logic [RSA_W-1:0]      o_core_N,
   input  logic [RSA_W-1:0]      i_core_result,
   input  logic                  i_core_end
);

   localparam int LW = $clog2(NREQ);

   state_t        state, state_nx;
   logic [LW-1:0] idx, last_winner, pick_idx;
   logic          pick_valid;
   logic          wd_expire;

   rsa32_rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
      .req   (i_req),
      .last  (last_winner),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (pick_valid) state_nx = START;
         START: state_nx = WAIT;
         WAIT:  if (i_core_end || wd_expire) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_core_start = (state == START);
      o_busy       = (state != IDLE);
      o_done       = (state == DONE) ? o_gnt : '0;
   end

   // Operands are sampled only at the grant edge; requesters are free to change them afterwards.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         idx         <= '0;
         last_winner <= LW'(NREQ - 1);
         o_gnt       <= '0;
         o_result    <= '0;
         o_core_base <= '0;
         o_core_exp  <= '0;
         o_core_N    <= '0;
      end else begin
         case (state)
            IDLE: if (pick_valid) begin
               idx         <= pick_idx;
               o_gnt       <= NREQ'(1) << pick_idx;
               o_core_base <= i_base[slot_lsb(int'(pick_idx)) +: RSA_W];
               o_core_exp  <= i_exp[slot_lsb(int'(pick_idx)) +: RSA_W];
               o_core_N    <= i_N[slot_lsb(int'(pick_idx)) +: RSA_W];
            end
            WAIT: begin
               if (i_core_end)     o_result <= i_core_result;
               else if (wd_expire) o_result <= '0;
            end
            DONE: begin
               o_gnt       <= '0;
               last_winner <= idx;
            end
            default: ;
         endcase
      end
   end

`ifdef RSA32_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wd_cnt;
   logic          timed_out;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)              wd_cnt <= '0;
      else if (state == WAIT)   wd_cnt <= wd_cnt + 1'b1;
      else                      wd_cnt <= '0;
   end

   assign wd_expire = (state == WAIT) && (wd_cnt == CW'(TIMEOUT));

   // A real end strobe in the expiry cycle takes priority over the abort.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)                                timed_out <= 1'b0;
      else if (wd_expire && !i_core_end)          timed_out <= 1'b1;
      else if (state == IDLE)                     timed_out <= 1'b0;
   end

   assign o_timeout = (state == DONE) && timed_out;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign wd_expire      = 1'b0;
   assign o_timeout      = 1'b0;
`endif

endmodule
